// File: rtl/wb_shared_arbiter.sv
// Two-master, one-slave Wishbone arbiter: the data bus (m0) and instruction bus (m1) share one slave.
// A grant is held for a whole cycle; a watchdog ends a hung strobe with a one-cycle error pulse.
module wb_shared_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_data_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic                m0_stb_i,
  input  logic                m0_cyc_i,
  output logic [DATA_W-1:0]   m0_data_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_data_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic                m1_stb_i,
  input  logic                m1_cyc_i,
  output logic [DATA_W-1:0]   m1_data_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_data_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic                s_stb_o,
  output logic                s_cyc_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_ack_i,
  output logic [1:0]          gnt_o
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_gnt;   // 1: m1 held the most recent grant
  logic [7:0] wd_cnt;

  logic req0, req1;
  logic own_stb, own_cyc;
  logic timeout;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Forward the owner's signals; IDLE drives the slave port to all zeros.
  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    own_stb  = 1'b0;
    own_cyc  = 1'b0;
    unique case (state)
      G0: begin
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        own_stb  = m0_stb_i;
        own_cyc  = m0_cyc_i;
      end
      G1: begin
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        own_stb  = m1_stb_i;
        own_cyc  = m1_cyc_i;
      end
      default: ;
    endcase
  end

  // An ack in the same cycle always beats the watchdog.
  assign timeout = own_stb & ~s_ack_i & (wd_cnt == WD_LAST);

  assign s_cyc_o   = own_cyc;
  assign s_stb_o   = own_stb & ~timeout;
  assign gnt_o     = {state == G1, state == G0};
  assign m0_ack_o  = (state == G0) & s_ack_i;
  assign m1_ack_o  = (state == G1) & s_ack_i;
  assign m0_data_o = (state == G0) ? s_data_i : '0;
  assign m1_data_o = (state == G1) ? s_data_i : '0;
  assign m0_err_o  = (state == G0) & timeout;
  assign m1_err_o  = (state == G1) & timeout;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wd_cnt   <= '0;
    end else begin
      if (state == IDLE || !own_cyc || !own_stb || s_ack_i || timeout)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 8'd1;

      unique case (state)
        IDLE: begin
          if (req0 && (!req1 || RR_MODE == 0 || last_gnt)) begin
            state    <= G0;
            last_gnt <= 1'b0;
          end else if (req1) begin
            state    <= G1;
            last_gnt <= 1'b1;
          end
        end
        G0:      if (!m0_cyc_i) state <= IDLE;
        G1:      if (!m1_cyc_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
